// File: rtl/berger_pkg.sv
// Shared types and constants for the Berger fault-injection campaign controller.
package berger_pkg;

    localparam int CODE_W_DEF = 12;

    localparam logic [1:0] DIR_Z2O  = 2'b00;
    localparam logic [1:0] DIR_O2Z  = 2'b01;
    localparam logic [1:0] DIR_BOTH = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // Both 2'b10 and 2'b11 run each mask in both directions.
    function automatic logic dir_is_both(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/berger_sat_counter.sv
// Tally counter with synchronous clear that sticks at all-ones instead of wrapping.
module berger_sat_counter #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/berger_fault_campaign_ctrl.sv
// Walks every non-zero error mask over one golden Berger codeword, drives the
// external injector and tallies the external checker's verdict per injection.
module berger_fault_campaign_ctrl
    import berger_pkg::*;
#(
    parameter int CODE_W    = CODE_W_DEF,
    parameter int CHECK_LAT = 1,
    parameter int CNT_W     = CODE_W + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        dir_mode,
    input  logic [CODE_W-1:0] base_code,
    output logic [CODE_W-1:0] inj_code,
    output logic [CODE_W-1:0] error_mask,
    output logic              fault_en,
    output logic              zero_to_one_error,
    input  logic [CODE_W-1:0] err_code_in,
    input  logic              chk_error,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cnt_effective,
    output logic [CNT_W-1:0]  cnt_detected,
    output logic [CNT_W-1:0]  cnt_missed,
    output logic [CNT_W-1:0]  cnt_false
);

    localparam logic [3:0] WAIT_INIT = 4'(CHECK_LAT - 1);

    state_t            state_reg;
    logic [CODE_W-1:0] code_reg;
    logic [CODE_W-1:0] mask_reg;
    logic              z2o_reg;
    logic [1:0]        mode_reg;
    logic              fault_en_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [3:0]        wait_cnt_reg;

    logic              start_ok;
    logic              sample_fire;
    logic              eff;
    logic [3:0]        inc_vec;
    logic [CNT_W-1:0]  cnt_arr [4];

    assign start_ok    = (state_reg == ST_IDLE) && start;
    // An abort landing on the sample cycle discards that verdict.
    assign sample_fire = (state_reg == ST_SAMPLE) && !abort;
    assign eff         = (err_code_in != code_reg);

    assign inc_vec = {sample_fire && !eff && chk_error,
                      sample_fire &&  eff && !chk_error,
                      sample_fire &&  eff &&  chk_error,
                      sample_fire &&  eff};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            berger_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (start_ok),
                .inc   (inc_vec[gi]),
                .count (cnt_arr[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            code_reg     <= '0;
            mask_reg     <= '0;
            z2o_reg      <= 1'b0;
            mode_reg     <= 2'b00;
            fault_en_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            wait_cnt_reg <= 4'd0;
        end else begin
            done_reg <= 1'b0;
            if ((state_reg != ST_IDLE) && abort) begin
                state_reg    <= ST_IDLE;
                fault_en_reg <= 1'b0;
                busy_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            code_reg     <= base_code;
                            mode_reg     <= dir_mode;
                            mask_reg     <= {{(CODE_W-1){1'b0}}, 1'b1};
                            z2o_reg      <= (dir_mode != DIR_O2Z);
                            fault_en_reg <= 1'b1;
                            busy_reg     <= 1'b1;
                            state_reg    <= ST_APPLY;
                        end
                    end
                    ST_APPLY: begin
                        wait_cnt_reg <= WAIT_INIT;
                        state_reg    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (wait_cnt_reg == 4'd0) begin
                            state_reg <= ST_SAMPLE;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg - 4'd1;
                        end
                    end
                    ST_SAMPLE: begin
                        if (dir_is_both(mode_reg) && z2o_reg) begin
                            z2o_reg   <= 1'b0;
                            state_reg <= ST_APPLY;
                        end else if (mask_reg == {CODE_W{1'b1}}) begin
                            fault_en_reg <= 1'b0;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= ST_DONE;
                        end else begin
                            mask_reg  <= mask_reg + 1'b1;
                            z2o_reg   <= (mode_reg != DIR_O2Z);
                            state_reg <= ST_APPLY;
                        end
                    end
                    ST_DONE: begin
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign inj_code          = code_reg;
    assign error_mask        = mask_reg;
    assign fault_en          = fault_en_reg;
    assign zero_to_one_error = z2o_reg;
    assign busy              = busy_reg;
    assign done              = done_reg;
    assign cnt_effective     = cnt_arr[0];
    assign cnt_detected      = cnt_arr[1];
    assign cnt_missed        = cnt_arr[2];
    assign cnt_false         = cnt_arr[3];

endmodule

// File: tb/tb_berger_fault_campaign_ctrl.sv
// Scoreboard bench: campaigns on a 4-bit and a 12-bit controller with a modelled injector/checker.
module tb_berger_fault_campaign_ctrl;

    localparam int W   = 4;
    localparam int L   = 1;
    localparam int CW  = W + 2;
    localparam int W2  = 12;
    localparam int L2  = 2;
    localparam int CW2 = W2 + 2;

    typedef struct {
        int eff;
        int det;
        int mis;
        int fal;
        int cyc;
    } exp_t;

    typedef struct {
        int eff;
        int det;
        int mis;
        int fal;
        int busy;
        int fen;
        int done;
        int mask;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0, abort = 1'b0;
    logic [1:0]    dir_mode = 2'b00;
    logic [W-1:0]  base_code = '0;
    logic [W-1:0]  inj_code, error_mask, err_code_in;
    logic          fault_en, zero_to_one_error, chk_error, busy, done;
    logic [CW-1:0] cnt_effective, cnt_detected, cnt_missed, cnt_false;
    int            chk_mode = 0;

    logic           start12 = 1'b0;
    logic [1:0]     dir_mode12 = 2'b00;
    logic [W2-1:0]  base_code12 = '0;
    logic [W2-1:0]  inj_code12, error_mask12, err_code12;
    logic           fault_en12, z2o12, busy12, done12;
    logic           chk_error12;
    logic [CW2-1:0] eff12, det12, mis12, fal12;

    exp_t  q_done[$];
    exp_t  q_done12[$];
    snap_t q_snap[$];
    int    n_checks = 0;
    int    n_pass = 0;

    // Stand-in checkers: 0 ideal, 1 stuck at 0, 2 stuck at 1, 3 real 2+2 Berger check.
    function automatic bit chk_fn(input int cm, input int f, input int base);
        int zeros;
        zeros = 2 - ((f >> 3) & 1) - ((f >> 2) & 1);
        case (cm)
            0:       return f != base;
            1:       return 1'b0;
            2:       return 1'b1;
            default: return (f & 3) != zeros;
        endcase
    endfunction

    function automatic int sat(input int v, input int maxc);
        return (v >= maxc) ? maxc : v + 1;
    endfunction

    // Reference: enumerate injections in campaign order; stop early after 'limit' when limit >= 0.
    function automatic exp_t model(input int w, input int lat, input int cntw, input int base,
                                   input int dm, input int cm, input int limit);
        exp_t e;
        int   n, all, maxc, f;
        bit   eff, c;
        e    = '{0, 0, 0, 0, 0};
        n    = 0;
        all  = (1 << w) - 1;
        maxc = (1 << cntw) - 1;
        for (int m = 1; m <= all; m++) begin
            for (int pass = 0; pass < 2; pass++) begin
                bit z2o;
                if (pass == 1 && dm < 2) break;
                z2o = (dm == 0) || (dm >= 2 && pass == 0);
                if (limit >= 0 && n == limit) return e;
                f   = z2o ? (base | m) : (base & ~m & all);
                eff = (f != base);
                c   = chk_fn(cm, f, base);
                if (eff) begin
                    e.eff = sat(e.eff, maxc);
                    if (c) e.det = sat(e.det, maxc);
                    else   e.mis = sat(e.mis, maxc);
                end else if (c) begin
                    e.fal = sat(e.fal, maxc);
                end
                e.cyc += lat + 2;
                n++;
            end
        end
        return e;
    endfunction

    always_comb begin
        if (!fault_en)              err_code_in = inj_code;
        else if (zero_to_one_error) err_code_in = inj_code | error_mask;
        else                        err_code_in = inj_code & ~error_mask;
        chk_error = chk_fn(chk_mode, int'(err_code_in), int'(inj_code));
    end

    always_comb begin
        if (!fault_en12) err_code12 = inj_code12;
        else if (z2o12)  err_code12 = inj_code12 | error_mask12;
        else             err_code12 = inj_code12 & ~error_mask12;
        chk_error12 = 1'b0;
    end

    berger_fault_campaign_ctrl #(.CODE_W(W), .CHECK_LAT(L), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dir_mode(dir_mode),
        .base_code(base_code), .inj_code(inj_code), .error_mask(error_mask),
        .fault_en(fault_en), .zero_to_one_error(zero_to_one_error),
        .err_code_in(err_code_in), .chk_error(chk_error), .busy(busy), .done(done),
        .cnt_effective(cnt_effective), .cnt_detected(cnt_detected),
        .cnt_missed(cnt_missed), .cnt_false(cnt_false)
    );

    berger_fault_campaign_ctrl #(.CODE_W(W2), .CHECK_LAT(L2), .CNT_W(CW2)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(start12), .abort(1'b0), .dir_mode(dir_mode12),
        .base_code(base_code12), .inj_code(inj_code12), .error_mask(error_mask12),
        .fault_en(fault_en12), .zero_to_one_error(z2o12),
        .err_code_in(err_code12), .chk_error(chk_error12), .busy(busy12), .done(done12),
        .cnt_effective(eff12), .cnt_detected(det12),
        .cnt_missed(mis12), .cnt_false(fal12)
    );

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, want);
    endtask

    // Monitor: sole owner of the check counters.
    initial begin
        int    busy_cyc = 0, busy_cyc12 = 0, fen_bad = 0;
        exp_t  e;
        snap_t s;
        forever begin
            @(negedge clk);
            if (fault_en != busy) fen_bad++;
            if (q_snap.size() > 0) begin
                s = q_snap.pop_front();
                check("snap_effective", int'(cnt_effective), s.eff);
                check("snap_detected",  int'(cnt_detected),  s.det);
                check("snap_missed",    int'(cnt_missed),    s.mis);
                check("snap_false",     int'(cnt_false),     s.fal);
                check("snap_busy",      int'(busy),          s.busy);
                check("snap_fault_en",  int'(fault_en),      s.fen);
                check("snap_done",      int'(done),          s.done);
                check("snap_mask",      int'(error_mask),    s.mask);
                $display("snapshot eff=%0d det=%0d mis=%0d fal=%0d busy=%0d fen=%0d mask=%0d",
                         cnt_effective, cnt_detected, cnt_missed, cnt_false, busy, fault_en, error_mask);
            end
            if (done) begin
                if (q_done.size() == 0) begin
                    check("unexpected_done", int'(done), 0);
                end else begin
                    e = q_done.pop_front();
                    check("effective",   int'(cnt_effective), e.eff);
                    check("detected",    int'(cnt_detected),  e.det);
                    check("missed",      int'(cnt_missed),    e.mis);
                    check("false",       int'(cnt_false),     e.fal);
                    check("busy_cycles", busy_cyc,            e.cyc);
                    check("fault_en_vs_busy", fen_bad, 0);
                    $display("campaign4 base=%0h eff=%0d det=%0d mis=%0d fal=%0d cycles=%0d",
                             inj_code, cnt_effective, cnt_detected, cnt_missed, cnt_false, busy_cyc);
                end
            end
            if (done12) begin
                if (q_done12.size() == 0) begin
                    check("unexpected_done12", int'(done12), 0);
                end else begin
                    e = q_done12.pop_front();
                    check("effective12",   int'(eff12), e.eff);
                    check("detected12",    int'(det12), e.det);
                    check("missed12",      int'(mis12), e.mis);
                    check("false12",       int'(fal12), e.fal);
                    check("busy_cycles12", busy_cyc12,  e.cyc);
                    $display("campaign12 base=%0h eff=%0d det=%0d mis=%0d fal=%0d cycles=%0d",
                             inj_code12, eff12, det12, mis12, fal12, busy_cyc12);
                end
            end
            if (busy)   busy_cyc++;   else busy_cyc = 0;
            if (busy12) busy_cyc12++; else busy_cyc12 = 0;
        end
    end

    task automatic wait_done(input bit wide, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (wide ? done12 : done) return;
        end
        $display("FAIL done_timeout: got no done within %0d cycles expected done pulse", budget);
        $fatal(1);
    endtask

    task automatic run4(input int base, input int dm, input int cm, input bit extra_start);
        @(negedge clk);
        base_code = W'(base);
        dir_mode  = 2'(dm);
        chk_mode  = cm;
        start     = 1'b1;
        q_done.push_back(model(W, L, CW, base, dm, cm, -1));
        @(negedge clk);
        start = 1'b0;
        if (extra_start) begin
            repeat (7) @(negedge clk);
            base_code = ~W'(base);
            dir_mode  = 2'(dm ^ 1);
            start     = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(1'b0, 2 * ((1 << W) - 1) * (L + 2) + 10);
    endtask

    initial begin
        exp_t ea;
        int   base;
        q_snap.push_back('{0, 0, 0, 0, 0, 0, 0, 0});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run4(0, 0, 0, 1'b0);
        run4(15, 0, 0, 1'b0);
        run4(5, 1, 2, 1'b0);

        // Abort on the sample cycle of mask 3: only masks 1 and 2 count.
        base = int'($urandom_range(0, 15));
        @(negedge clk);
        base_code = W'(base);
        dir_mode  = 2'b00;
        chk_mode  = 3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * L + 5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ea = model(W, L, CW, base, 0, 3, 2);
        q_snap.push_back('{ea.eff, ea.det, ea.mis, ea.fal, 0, 0, 0, 3});
        repeat (6) @(negedge clk);

        // Reset during WAIT, then a campaign that sees a stray start while busy.
        @(negedge clk);
        base_code = W'($urandom_range(1, 15));
        dir_mode  = 2'b10;
        chk_mode  = 2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        q_snap.push_back('{0, 0, 0, 0, 0, 0, 0, 0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run4(int'($urandom_range(0, 15)), 2, 3, 1'b1);

        for (int i = 0; i < 20; i++) begin
            run4(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Full 12-bit campaign, both directions, checker stuck at 0.
        @(negedge clk);
        base_code12 = 12'hA5C;
        dir_mode12  = 2'b10;
        start12     = 1'b1;
        q_done12.push_back(model(W2, L2, CW2, 'hA5C, 2, 1, -1));
        @(negedge clk);
        start12 = 1'b0;
        wait_done(1'b1, 2 * ((1 << W2) - 1) * (L2 + 2) + 10);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
